// File: rtl/int_step_executor_pkg.sv
// Shared definitions for the interrupt step-code executor: step codes,
// FSM state encoding and default datapath widths.
package int_pkg;

    localparam int DATA_W_DFLT = 16;
    localparam int PC_W_DFLT   = 32;
    localparam int ADDR_W_DFLT = 20;

    localparam logic [3:0] STEP_NOP        = 4'b0000;
    localparam logic [3:0] STEP_PUSH_PC    = 4'b0001;
    localparam logic [3:0] STEP_PUSH_FLAGS = 4'b0011;
    localparam logic [3:0] STEP_FETCH_VEC  = 4'b0111;
    localparam logic [3:0] STEP_COMMIT     = 4'b1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_LO   = 2'd2,
        RD_HI   = 2'd3
    } state_e;

endpackage

// File: rtl/int_mem_port.sv
// Single-outstanding request/ack stage: captures one access on start and
// holds mem_* stable until the acknowledge is sampled.
module int_mem_port
    import int_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack
);

    // An acknowledge seen while no request is outstanding is ignored.
    assign done = mem_req & mem_ack;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (mem_req) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
            end
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= we;
            mem_addr  <= addr;
            mem_wdata <= wdata;
        end
    end

endmodule

// File: rtl/int_step_executor.sv
// Interrupt step-code consumer: pushes PC/flags, fetches the vector and
// commits the new PC/SP to the fetch stage.
module int_step_executor
    import int_pkg::*;
#(
    parameter int          DATA_W   = DATA_W_DFLT,
    parameter int          PC_W     = PC_W_DFLT,
    parameter int          ADDR_W   = ADDR_W_DFLT,
    parameter int          FLAG_W   = 4,
    parameter int unsigned VEC_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        step_code,
    input  logic              step_valid,
    output logic              step_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [PC_W-1:0]   pc_out,
    output logic              pc_load,
    output logic [ADDR_W-1:0] sp_out,
    output logic              sp_load,
    output logic              int_active,
    input  logic              int_clr,
    output logic              seq_err
);

    localparam logic [ADDR_W-1:0] VEC_LO = ADDR_W'(VEC_ADDR);
    localparam logic [ADDR_W-1:0] VEC_HI = ADDR_W'(VEC_ADDR + 1);

    state_e            state;
    logic [1:0]        push_cnt;
    logic              vec_ok;
    logic [PC_W-1:0]   pc_sh;
    logic [FLAG_W-1:0] flags_sh;
    logic [ADDR_W-1:0] sp_sh;

    logic              accept;
    logic              mem_done;
    logic              iss_start;
    logic              iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;

    assign step_ready = (state == IDLE);
    assign accept     = step_valid & step_ready;

    // Memory access launched by the code being accepted (or the second vector read).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        iss_start = 1'b0;
        iss_we    = 1'b0;
        iss_addr  = '0;
        iss_wdata = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (step_code)
                        STEP_PUSH_PC: begin
                            if (push_cnt == 2'd0) begin
                                iss_start = 1'b1;
                                iss_we    = 1'b1;
                                iss_addr  = sp_in;
                                iss_wdata = pc_in[PC_W-1:DATA_W];
                            end else if (push_cnt == 2'd1) begin
                                iss_start = 1'b1;
                                iss_we    = 1'b1;
                                iss_addr  = sp_sh;
                                iss_wdata = pc_sh[DATA_W-1:0];
                            end
                        end
                        STEP_PUSH_FLAGS: begin
                            if (push_cnt >= 2'd2) begin
                                iss_start = 1'b1;
                                iss_we    = 1'b1;
                                iss_addr  = sp_sh;
                                iss_wdata = DATA_W'(flags_sh);
                            end
                        end
                        STEP_FETCH_VEC: begin
                            iss_start = 1'b1;
                            iss_addr  = VEC_LO;
                        end
                        default: ;
                    endcase
                end
            end
            RD_HI: begin
                iss_start = ~mem_req;
                iss_addr  = VEC_HI;
            end
            default: ;
        endcase
    end

    int_mem_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_port (
        .clk       (clk),
        .rst       (rst),
        .start     (iss_start),
        .we        (iss_we),
        .addr      (iss_addr),
        .wdata     (iss_wdata),
        .done      (mem_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            push_cnt   <= 2'd0;
            vec_ok     <= 1'b0;
            pc_sh      <= '0;
            flags_sh   <= '0;
            sp_sh      <= '0;
            pc_out     <= '0;
            sp_out     <= '0;
            pc_load    <= 1'b0;
            sp_load    <= 1'b0;
            int_active <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            sp_load <= 1'b0;
            seq_err <= 1'b0;
            if (int_clr) begin
                int_active <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        case (step_code)
                            STEP_NOP: ;
                            STEP_PUSH_PC: begin
                                unique case (push_cnt)
                                    2'd0: begin
                                        pc_sh    <= pc_in;
                                        flags_sh <= flags_in;
                                        sp_sh    <= sp_in;
                                        state    <= WR_WAIT;
                                    end
                                    2'd1: state <= WR_WAIT;
                                    2'd2: ;
                                    2'd3: seq_err <= 1'b1;
                                endcase
                                if (push_cnt != 2'd3) begin
                                    push_cnt <= push_cnt + 2'd1;
                                end
                            end
                            STEP_PUSH_FLAGS: begin
                                if (push_cnt >= 2'd2) begin
                                    state <= WR_WAIT;
                                end else begin
                                    seq_err <= 1'b1;
                                end
                            end
                            STEP_FETCH_VEC: state <= RD_LO;
                            STEP_COMMIT: begin
                                if (vec_ok) begin
                                    pc_out     <= pc_sh;
                                    sp_out     <= sp_sh;
                                    pc_load    <= 1'b1;
                                    sp_load    <= 1'b1;
                                    int_active <= 1'b1;
                                    push_cnt   <= 2'd0;
                                    vec_ok     <= 1'b0;
                                end else begin
                                    seq_err <= 1'b1;
                                end
                            end
                            default: seq_err <= 1'b1;
                        endcase
                    end
                end
                WR_WAIT: begin
                    if (mem_done) begin
                        sp_sh <= sp_sh - 1'b1;
                        state <= IDLE;
                    end
                end
                RD_LO: begin
                    if (mem_done) begin
                        pc_sh[DATA_W-1:0] <= mem_rdata;
                        state             <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (mem_done) begin
                        pc_sh[PC_W-1:DATA_W] <= mem_rdata;
                        vec_ok               <= 1'b1;
                        state                <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_step_executor.sv
// Directed bench for int_step_executor with a small acking memory model.
module tb_int_step_executor;
    import int_pkg::*;

    localparam int DATA_W = 16;
    localparam int PC_W   = 32;
    localparam int ADDR_W = 20;
    localparam int FLAG_W = 4;

    logic              clk;
    logic              rst;
    logic [3:0]        step_code;
    logic              step_valid;
    logic              step_ready;
    logic [PC_W-1:0]   pc_in;
    logic [FLAG_W-1:0] flags_in;
    logic [ADDR_W-1:0] sp_in;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [PC_W-1:0]   pc_out;
    logic              pc_load;
    logic [ADDR_W-1:0] sp_out;
    logic              sp_load;
    logic              int_active;
    logic              int_clr;
    logic              seq_err;

    int checks = 0;
    int errors = 0;

    // Memory model state and observation flags
    logic [DATA_W-1:0] vmem [2];
    int                ack_delay = 0;
    int                wait_cnt;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_wdata;
    logic              held_we;
    logic              unstable;
    logic              ready_in_req;
    int                wr_n;
    logic [ADDR_W-1:0] wr_addr [8];
    logic [DATA_W-1:0] wr_data [8];
    int                n_pc_load;
    int                n_sp_load;
    int                n_seq_err;
    logic              load_skew;

    int_step_executor #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .ADDR_W   (ADDR_W),
        .FLAG_W   (FLAG_W),
        .VEC_ADDR (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_code  (step_code),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .pc_in      (pc_in),
        .flags_in   (flags_in),
        .sp_in      (sp_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .pc_out     (pc_out),
        .pc_load    (pc_load),
        .sp_out     (sp_out),
        .sp_load    (sp_load),
        .int_active (int_active),
        .int_clr    (int_clr),
        .seq_err    (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: acks after ack_delay falling edges, logs writes.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst || mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) begin
                    held_addr  = mem_addr;
                    held_wdata = mem_wdata;
                    held_we    = mem_we;
                end else if (mem_addr !== held_addr || mem_wdata !== held_wdata ||
                             mem_we !== held_we) begin
                    unstable = 1'b1;
                end
                if (step_ready) ready_in_req = 1'b1;
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        if (wr_n < 8) begin
                            wr_addr[wr_n] = mem_addr;
                            wr_data[wr_n] = mem_wdata;
                        end
                        wr_n++;
                    end else begin
                        mem_rdata = (mem_addr < 2) ? vmem[mem_addr[0]] : '0;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Pulse monitor
    initial begin
        forever begin
            @(negedge clk);
            if (pc_load) n_pc_load++;
            if (sp_load) n_sp_load++;
            if (seq_err) n_seq_err++;
            if (pc_load !== sp_load) load_skew = 1'b1;
        end
    end

    task automatic clear_obs();
        wr_n         = 0;
        n_pc_load    = 0;
        n_sp_load    = 0;
        n_seq_err    = 0;
        load_skew    = 1'b0;
        unstable     = 1'b0;
        ready_in_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        int_clr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
    endtask

    task automatic send(input logic [3:0] c);
        int n;
        step_code  = c;
        step_valid = 1'b1;
        n = 0;
        while (!step_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout: code %b not accepted within 200 cycles, step_ready=%b", c, step_ready);
        end
        @(posedge clk);
        #1;
        step_valid = 1'b0;
    endtask

    task automatic run_full_seq(input string tag, input bit inject);
        logic [ADDR_W-1:0] ea [3];
        logic [DATA_W-1:0] ed [3];
        ea[0] = 20'h00100; ed[0] = 16'h0001;
        ea[1] = 20'h000FF; ed[1] = 16'h2345;
        ea[2] = 20'h000FE; ed[2] = 16'h0005;
        clear_obs();
        sp_in    = 20'h00100;
        pc_in    = 32'h0001_2345;
        flags_in = 4'h5;
        send(STEP_PUSH_PC);
        if (inject) begin
            send(4'b0101);
            send(STEP_NOP);
        end
        send(STEP_PUSH_PC);
        send(STEP_PUSH_PC);
        send(STEP_PUSH_FLAGS);
        send(STEP_FETCH_VEC);
        send(STEP_COMMIT);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_n !== 3) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want 3", tag, wr_n);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
                errors++;
                $display("FAIL %s_write%0d: got %h@%h want %h@%h", tag, i, wr_data[i], wr_addr[i], ed[i], ea[i]);
            end
        end
        checks++;
        if (pc_out !== 32'h0000_0040) begin
            errors++;
            $display("FAIL %s_pc_out: got %h want 00000040", tag, pc_out);
        end
        checks++;
        if (sp_out !== 20'h000FD) begin
            errors++;
            $display("FAIL %s_sp_out: got %h want 000fd", tag, sp_out);
        end
        checks++;
        if (n_pc_load !== 1 || n_sp_load !== 1 || load_skew !== 1'b0) begin
            errors++;
            $display("FAIL %s_loads: pc_load %0d sp_load %0d skew %b want 1 1 0", tag, n_pc_load, n_sp_load, load_skew);
        end
        checks++;
        if (int_active !== 1'b1) begin
            errors++;
            $display("FAIL %s_int_active: got %b want 1", tag, int_active);
        end
        checks++;
        if (n_seq_err !== (inject ? 1 : 0)) begin
            errors++;
            $display("FAIL %s_seq_err: got %0d pulses want %0d", tag, n_seq_err, inject ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (step_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || pc_load !== 1'b0 ||
            sp_load !== 1'b0 || int_active !== 1'b0 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready %b req %b we %b pl %b sl %b act %b err %b want 1 0 0 0 0 0 0",
                     step_ready, mem_req, mem_we, pc_load, sp_load, int_active, seq_err);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || pc_out !== '0 || sp_out !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h pc %h sp %h want all 0", mem_addr, mem_wdata, pc_out, sp_out);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
    endtask

    task automatic test_zero_wait();
        do_reset();
        ack_delay = 0;
        run_full_seq("zero_wait", 1'b0);
    endtask

    task automatic test_delayed_ack();
        do_reset();
        ack_delay = 3;
        run_full_seq("delayed", 1'b0);
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL delayed_stable: got unstable=%b want 0", unstable);
        end
        checks++;
        if (ready_in_req !== 1'b0) begin
            errors++;
            $display("FAIL delayed_ready: step_ready seen high during wait=%b want 0", ready_in_req);
        end
        ack_delay = 0;
        @(negedge clk);
        int_clr = 1'b1;
        @(negedge clk);
        int_clr = 1'b0;
        checks++;
        if (int_active !== 1'b0) begin
            errors++;
            $display("FAIL int_clr: int_active got %b want 0", int_active);
        end
    endtask

    task automatic test_commit_early();
        do_reset();
        send(STEP_COMMIT);
        repeat (3) @(negedge clk);
        checks++;
        if (n_seq_err !== 1) begin
            errors++;
            $display("FAIL early_commit_seq_err: got %0d pulses want 1", n_seq_err);
        end
        checks++;
        if (n_pc_load !== 0 || int_active !== 1'b0) begin
            errors++;
            $display("FAIL early_commit_effect: pc_load %0d int_active %b want 0 0", n_pc_load, int_active);
        end
    endtask

    task automatic test_sp_wrap();
        do_reset();
        sp_in    = 20'h00000;
        pc_in    = 32'hABCD_1234;
        flags_in = 4'h0;
        send(STEP_PUSH_PC);
        send(STEP_PUSH_PC);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_n !== 2 || wr_addr[0] !== 20'h00000 || wr_data[0] !== 16'hABCD) begin
            errors++;
            $display("FAIL wrap_first: n %0d got %h@%h want abcd@00000", wr_n, wr_data[0], wr_addr[0]);
        end
        checks++;
        if (wr_addr[1] !== 20'hFFFFF || wr_data[1] !== 16'h1234 || n_seq_err !== 0) begin
            errors++;
            $display("FAIL wrap_second: got %h@%h err %0d want 1234@fffff err 0", wr_data[1], wr_addr[1], n_seq_err);
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        do_reset();
        run_full_seq("pre_reset", 1'b0);
        ack_delay = 5;
        send(STEP_PUSH_PC);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!mem_req) begin
            errors++;
            $display("FAIL midop_req: mem_req got %b want 1 before reset", mem_req);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL midop_mem: req %b we %b addr %h wdata %h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (int_active !== 1'b0 || pc_out !== '0 || sp_out !== '0 || step_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_state: act %b pc %h sp %h ready %b want 0 0 0 1", int_active, pc_out, sp_out, step_ready);
        end
        @(negedge clk);
        rst       = 1'b1;
        ack_delay = 0;
        run_full_seq("post_reset", 1'b0);
    endtask

    task automatic test_illegal_nop();
        do_reset();
        ack_delay = 0;
        run_full_seq("illegal_nop", 1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        step_code  = STEP_NOP;
        step_valid = 1'b0;
        pc_in      = '0;
        flags_in   = '0;
        sp_in      = '0;
        int_clr    = 1'b0;
        vmem[0]    = 16'h0040;
        vmem[1]    = 16'h0000;
        clear_obs();
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_commit_early();
        test_sp_wrap();
        test_reset_mid_op();
        test_illegal_nop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_step_executor.md
Name: int_step_executor

Overview:
- Consumer end of the interrupt step-code interface.
- The interrupt controller emits a 4-bit step sequence: 0001 x3, 0011, 0111, 1000. This block turns each code into datapath actions:
  - push PC and flags to the stack,
  - fetch the interrupt vector,
  - commit the new PC/SP to the fetch stage.
- Sits between the interrupt controller, the data-memory port and the PC/SP registers.

Parameters:
- DATA_W, 16, memory word width.
- PC_W, 32, program counter width; pushed and loaded as two DATA_W halves.
- ADDR_W, 20, data-memory address / SP width.
- FLAG_W, 4, CCR flag width; zero-extended to DATA_W on push.
- VEC_ADDR, 0, address of the vector's low word; the high word is at VEC_ADDR+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- step_code  in  4  step code from the interrupt controller
- step_valid  in  1  step_code is valid
- step_ready  out  1  executor can accept a code this cycle
- pc_in  in  PC_W  return PC from the fetch stage
- flags_in  in  FLAG_W  current CCR flags
- sp_in  in  ADDR_W  current stack pointer
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  request complete
- pc_out  out  PC_W  interrupt-vector PC
- pc_load  out  1  one-cycle pulse: load pc_out into the PC
- sp_out  out  ADDR_W  updated SP
- sp_load  out  1  one-cycle pulse, same cycle as pc_load
- int_active  out  1  set at commit, cleared by int_clr
- int_clr  in  1  return-from-interrupt clears int_active
- seq_err  out  1  one-cycle pulse on an out-of-order or illegal code

Behaviour:
- Reset values (asynchronous, active-low):
  - state=IDLE, step_ready=1.
  - mem_req, mem_we, pc_load, sp_load, int_active, seq_err = 0.
  - mem_addr, mem_wdata, pc_out, sp_out = 0.
  - push_cnt=0, vec_ok=0.
- Handshake: a code is accepted when step_valid and step_ready are both 1. step_ready=1 only in IDLE. The producer holds its code while step_ready=0.
- FSM states: IDLE, WR_WAIT, RD_LO, RD_HI.
- Code 0001 (PUSH_PC):
  - push_cnt=0: latch pc_in, flags_in and sp_in into shadow registers. Write PC[31:16] at sp_shadow. Go to WR_WAIT.
  - push_cnt=1: write PC[15:0] at sp_shadow. Go to WR_WAIT.
  - push_cnt=2: drain step, no memory access, stay in IDLE.
  - push_cnt increments after each of these three cases, saturating at 3.
- Code 0011 (PUSH_FLAGS):
  - Legal only when push_cnt>=2; writes zero-extended flags at sp_shadow.
  - Otherwise: pulse seq_err, drop the code.
- Code 0111 (FETCH_VEC): read VEC_ADDR (RD_LO), then VEC_ADDR+1 (RD_HI). Assemble pc_shadow = {hi, lo}, then set vec_ok=1.
- Code 1000 (COMMIT):
  - If vec_ok=1: in the cycle after acceptance, pc_out = assembled vector, sp_out = sp_shadow, and pc_load, sp_load pulse for 1 cycle. int_active <= 1; push_cnt and vec_ok clear.
  - If vec_ok=0: pulse seq_err; no loads.
- Code 0000: NOP, accepted, no effect.
- Any other code: pulse seq_err, drop.
- Every write: SP post-decrements (sp_shadow <= sp_shadow-1) in the mem_ack cycle. Wraps modulo 2^ADDR_W with no error.
- Memory protocol:
  - mem_req rises the cycle after acceptance.
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - mem_req drops in the cycle mem_ack is sampled high; the FSM returns to IDLE or advances to RD_HI.
  - mem_ack while mem_req=0 is ignored.
  - Latency per code: 1 cycle + memory wait (0 extra for drain/NOP).
- int_clr and commit in the same cycle: commit wins; int_active=1.
- Reset mid-operation: mem_req drops immediately (async). Partial pushes are abandoned and not retried.

Decomposition:
- Shared package int_pkg holds:
  - step-code constants: STEP_NOP=0000, STEP_PUSH_PC=0001, STEP_PUSH_FLAGS=0011, STEP_FETCH_VEC=0111, STEP_COMMIT=1000.
  - the FSM state encoding.
  - DATA_W, PC_W and ADDR_W defaults.
- One natural sub-module: int_mem_port, the single-outstanding request/ack register stage driving mem_*.

Test Plan:
- Full sequence with zero-wait mem_ack:
  - Setup: sp_in=0x00100, pc_in=0x0001_2345, flags_in=0x5, mem[0]=0x0040, mem[1]=0x0000.
  - Writes: 0x0001@0x00100, 0x2345@0x000FF, 0x0005@0x000FE.
  - Commit: pc_out=0x0000_0040, sp_out=0x000FD, pc_load and sp_load pulse once, int_active=1.
- Same sequence with mem_ack delayed 3 cycles per access: step_ready stays 0 during each wait, mem_addr/mem_wdata stay stable, final result is identical.
- COMMIT before FETCH_VEC: seq_err pulses 1 cycle, no pc_load, int_active stays 0.
- sp_in=0x00000: first write at 0x00000, second at 0xFFFFF (wrap), no error.
- Reset asserted while mem_req=1 mid-push: all outputs go to reset values without a clock edge. A fresh full sequence then completes correctly.
- Illegal code 0101 and a NOP interleaved: 0101 gives a seq_err pulse, NOP has no effect, the remaining sequence result is unchanged.
